issue_readop: RTL and testbench

//  Operand-read stage between issue_rs and the execution units. Pops one ready uop per cycle

---
 rtl/issue_readop.sv | 179 +++++++++++++++++
 tb/tb_issue_readop.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_readop.sv
// issue_readop: operand-read stage sitting between the reservation station and
// the execution units.
//
// A ready uop is popped from the RS, both source operands are read from the
// physical register file (one-cycle synchronous read), and writebacks that land
// while the read is in flight are bypassed in.  The uop and its final operands
// are then presented to EX from an output register with a valid/ready handshake.
//
// Pipeline: S1 (PRF read in flight / held uop) -> S2 (output register to EX).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    kills everything in S1 and S2, blocks the pop
//   ro_valid / ro_rs_pop     RS offers a uop / uop accepted this cycle
//   ro_prs1/2, ro_prs1/2_re  source physical registers and their use flags
//   ro_imm, ro_opp           immediate and opaque payload
//   prf_re, prf_raddr1/2     PRF read request (issued in the pop cycle)
//   prf_rdat1/2              PRF read data, valid the cycle after prf_re
//   wb_we, wb_prd, wb_dat    writeback ports, port k at [k*W +: W]
//   ex_valid / ex_ready      S2 handshake to EX
//   ex_operand1/2, ex_opp    resolved operands and payload

`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module issue_readop #(
  parameter int CONFIG_DW   = 64,
  parameter int CONFIG_P_WB = 1,
  parameter int OPP_W       = 128
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        flush,
  input  logic                                        ro_valid,
  output logic                                        ro_rs_pop,
  input  logic [`NCPU_PRF_AW-1:0]                     ro_prs1,
  input  logic                                        ro_prs1_re,
  input  logic [`NCPU_PRF_AW-1:0]                     ro_prs2,
  input  logic                                        ro_prs2_re,
  input  logic [CONFIG_DW-1:0]                        ro_imm,
  input  logic [OPP_W-1:0]                            ro_opp,
  output logic                                        prf_re,
  output logic [`NCPU_PRF_AW-1:0]                     prf_raddr1,
  output logic [`NCPU_PRF_AW-1:0]                     prf_raddr2,
  input  logic [CONFIG_DW-1:0]                        prf_rdat1,
  input  logic [CONFIG_DW-1:0]                        prf_rdat2,
  input  logic [(1<<CONFIG_P_WB)-1:0]                 wb_we,
  input  logic [(1<<CONFIG_P_WB)*`NCPU_PRF_AW-1:0]    wb_prd,
  input  logic [(1<<CONFIG_P_WB)*CONFIG_DW-1:0]       wb_dat,
  output logic                                        ex_valid,
  input  logic                                        ex_ready,
  output logic [CONFIG_DW-1:0]                        ex_operand1,
  output logic [CONFIG_DW-1:0]                        ex_operand2,
  output logic [OPP_W-1:0]                            ex_opp
);

  localparam int WB_N = 1 << CONFIG_P_WB;
  localparam int AW   = `NCPU_PRF_AW;

  logic                 s1_valid;
  logic [AW-1:0]        s1_prs1, s1_prs2;
  logic                 s1_re1, s1_re2;
  logic [CONFIG_DW-1:0] s1_imm;
  logic [OPP_W-1:0]     s1_opp;
  logic                 s1_hit1, s1_hit2;
  logic [CONFIG_DW-1:0] s1_dat1, s1_dat2;
  logic                 s1_resolved;

  logic s2_adv, s1_adv, s1_free, pop;

  logic                 early_hit1, early_hit2, late_hit1, late_hit2;
  logic [CONFIG_DW-1:0] early_dat1, early_dat2, late_dat1, late_dat2;
  logic [CONFIG_DW-1:0] res1, res2;

  assign s2_adv  = ~ex_valid | ex_ready;
  assign s1_adv  = s1_valid & s2_adv;
  assign s1_free = ~s1_valid | s2_adv;

  // Internal pop drives the S1 loads; the reset gate only keeps the RS from
  // freeing an entry while reset is held (S1 is held clear by reset anyway).
  assign pop        = ro_valid & s1_free & ~flush;
  assign ro_rs_pop  = pop & ~rst;
  assign prf_re     = ro_rs_pop;
  assign prf_raddr1 = ro_prs1;
  assign prf_raddr2 = ro_prs2;

  // Writeback match against the incoming sources (early, pop cycle) and the
  // sources held in S1 (late, read-data cycle).  The loop runs from the top
  // port down so the lowest matching port wins.
  always_comb begin
    early_hit1 = 1'b0;
    early_hit2 = 1'b0;
    late_hit1  = 1'b0;
    late_hit2  = 1'b0;
    early_dat1 = '0;
    early_dat2 = '0;
    late_dat1  = '0;
    late_dat2  = '0;
    for (int k = WB_N - 1; k >= 0; k--) begin
      if (wb_we[k] && (wb_prd[k*AW +: AW] == ro_prs1)) begin
        early_hit1 = 1'b1;
        early_dat1 = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
      if (wb_we[k] && (wb_prd[k*AW +: AW] == ro_prs2)) begin
        early_hit2 = 1'b1;
        early_dat2 = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
      if (wb_we[k] && (wb_prd[k*AW +: AW] == s1_prs1)) begin
        late_hit1 = 1'b1;
        late_dat1 = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
      if (wb_we[k] && (wb_prd[k*AW +: AW] == s1_prs2)) begin
        late_hit2 = 1'b1;
        late_dat2 = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
    end
  end

  // Operand resolution for the uop in S1.  Once S1 has latched its operands
  // (stalled behind S2) the PRF data is gone, so the latched copy is final.
  always_comb begin
    if (s1_resolved) begin
      res1 = s1_dat1;
      res2 = s1_dat2;
    end else begin
      res1 = late_hit1 ? late_dat1 : (s1_hit1 ? s1_dat1 : prf_rdat1);
      res2 = late_hit2 ? late_dat2 : (s1_hit2 ? s1_dat2 : prf_rdat2);
      if (!s1_re1) res1 = '0;
      if (!s1_re2) res2 = s1_imm;
    end
  end

  // Stage valids: the only state that needs reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      ex_valid <= 1'b0;
    end else begin
      s1_valid <= pop | (s1_valid & ~s2_adv);
      ex_valid <= s1_adv | (ex_valid & ~ex_ready);
    end
  end

  // S1 payload.  On pop the early bypass result is parked in s1_dat; on a
  // stall the resolved operands overwrite it and the entry is marked final.
  always_ff @(posedge clk) begin
    if (pop) begin
      s1_prs1     <= ro_prs1;
      s1_prs2     <= ro_prs2;
      s1_re1      <= ro_prs1_re;
      s1_re2      <= ro_prs2_re;
      s1_imm      <= ro_imm;
      s1_opp      <= ro_opp;
      s1_hit1     <= early_hit1;
      s1_hit2     <= early_hit2;
      s1_dat1     <= early_dat1;
      s1_dat2     <= early_dat2;
      s1_resolved <= 1'b0;
    end else if (s1_valid && !s2_adv) begin
      s1_dat1     <= res1;
      s1_dat2     <= res2;
      s1_resolved <= 1'b1;
    end
  end

  // S2 output register: loaded only when S1 advances, otherwise held.
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      ex_operand1 <= res1;
      ex_operand2 <= res2;
      ex_opp      <= s1_opp;
    end
  end

endmodule

// File: tb/tb_issue_readop.sv
// tb_issue_readop: directed bench for issue_readop.
//
// A behavioural PRF model feeds the DUT.  A separate reference model keeps its
// own register file and, for every uop popped, takes the register value as it
// stands after the writebacks of the pop cycle and the following cycle; the
// reference queue of finished uops is compared against S2 every cycle.  A few
// literal expectations per scenario pin the model itself.

`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

module tb_issue_readop;

  localparam int DW   = 64;
  localparam int PWB  = 1;
  localparam int OW   = 128;
  localparam int WB_N = 1 << PWB;
  localparam int AW   = `NCPU_PRF_AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 ro_valid;
  logic                 ro_rs_pop;
  logic [AW-1:0]        ro_prs1, ro_prs2;
  logic                 ro_prs1_re, ro_prs2_re;
  logic [DW-1:0]        ro_imm;
  logic [OW-1:0]        ro_opp;
  logic                 prf_re;
  logic [AW-1:0]        prf_raddr1, prf_raddr2;
  logic [DW-1:0]        prf_rdat1, prf_rdat2;
  logic [WB_N-1:0]      wb_we;
  logic [WB_N*AW-1:0]   wb_prd;
  logic [WB_N*DW-1:0]   wb_dat;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [DW-1:0]        ex_operand1, ex_operand2;
  logic [OW-1:0]        ex_opp;

  always #5 clk = ~clk;

  issue_readop #(.CONFIG_DW(DW), .CONFIG_P_WB(PWB), .OPP_W(OW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ro_valid(ro_valid), .ro_rs_pop(ro_rs_pop),
    .ro_prs1(ro_prs1), .ro_prs1_re(ro_prs1_re),
    .ro_prs2(ro_prs2), .ro_prs2_re(ro_prs2_re),
    .ro_imm(ro_imm), .ro_opp(ro_opp),
    .prf_re(prf_re), .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_rdat1(prf_rdat1), .prf_rdat2(prf_rdat2),
    .wb_we(wb_we), .wb_prd(wb_prd), .wb_dat(wb_dat),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2), .ex_opp(ex_opp)
  );

  int pass_count = 0;
  int total_count = 0;

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 64'h11;
    if (i == 6) return 64'h22;
    return 64'h1000 + 64'(i);
  endfunction

  function automatic logic [OW-1:0] mk_opp(input int tag);
    return {64'hFACE_0000_0000_0000 + 64'(tag), 64'(tag)};
  endfunction

  // Environment PRF: one-cycle read, writeback write at the edge (a read in
  // the same cycle sees the old value), junk on the read port when idle.
  logic [DW-1:0] prf_mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) prf_mem[i] <= init_val(i);
    end else begin
      if (prf_re) begin
        prf_rdat1 <= prf_mem[prf_raddr1];
        prf_rdat2 <= prf_mem[prf_raddr2];
      end else begin
        prf_rdat1 <= 64'hDEAD_BEEF_DEAD_BEEF;
        prf_rdat2 <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
      for (int k = 0; k < WB_N; k++)
        if (wb_we[k]) prf_mem[wb_prd[k*AW +: AW]] <= wb_dat[k*DW +: DW];
    end
  end

  // Reference model state
  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [OW-1:0] opp;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] gold [0:63];
  bit            p_valid = 1'b0;
  logic [AW-1:0] p_prs1, p_prs2;
  logic          p_re1, p_re2;
  logic [DW-1:0] p_imm;
  logic [OW-1:0] p_opp;
  logic [DW-1:0] got1 [0:255];
  logic [DW-1:0] got2 [0:255];
  bit            seen [0:255];

  // The stage holds at most two uops; one may enter whenever a slot is free
  // or EX is taking the oldest one this cycle.
  function automatic bit pop_expected();
    int inflight;
    inflight = int'(p_valid) + q.size();
    return ro_valid && !flush && !rst &&
           ((inflight < 2) || (q.size() > 0 && ex_ready));
  endfunction

  task automatic check_output(input string name, input logic [OW-1:0] act,
                              input logic [OW-1:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      got1[i] = '0;
      got2[i] = '0;
      seen[i] = 1'b0;
    end
  end

  // Reference model update at every edge
  initial begin
    bit     pe;
    exp_t   e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        p_valid = 1'b0;
        for (int i = 0; i < 64; i++) gold[i] = init_val(i);
      end else begin
        pe = pop_expected();
        if (flush) begin
          q.delete();
          p_valid = 1'b0;
        end else if (q.size() > 0 && ex_ready) begin
          seen[ex_opp[7:0]] = 1'b1;
          got1[ex_opp[7:0]] = ex_operand1;
          got2[ex_opp[7:0]] = ex_operand2;
          void'(q.pop_front());
        end
        for (int k = 0; k < WB_N; k++)
          if (wb_we[k]) gold[wb_prd[k*AW +: AW]] = wb_dat[k*DW +: DW];
        if (p_valid && !flush) begin
          e.op1 = p_re1 ? gold[p_prs1] : '0;
          e.op2 = p_re2 ? gold[p_prs2] : p_imm;
          e.opp = p_opp;
          q.push_back(e);
        end
        p_valid = 1'b0;
        if (pe) begin
          p_valid = 1'b1;
          p_prs1 = ro_prs1;
          p_prs2 = ro_prs2;
          p_re1  = ro_prs1_re;
          p_re2  = ro_prs2_re;
          p_imm  = ro_imm;
          p_opp  = ro_opp;
        end
      end
    end
  end

  // Per-cycle compare, half a period away from the active edge
  initial begin
    bit pe;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pe = pop_expected();
        check_output("ex_valid", OW'(ex_valid), OW'(q.size() > 0));
        check_output("ro_rs_pop", OW'(ro_rs_pop), OW'(pe));
        check_output("prf_re", OW'(prf_re), OW'(pe));
        if (pe) begin
          check_output("prf_raddr1", OW'(prf_raddr1), OW'(ro_prs1));
          check_output("prf_raddr2", OW'(prf_raddr2), OW'(ro_prs2));
        end
        if (ex_valid && q.size() > 0) begin
          check_output("ex_operand1", OW'(ex_operand1), OW'(q[0].op1));
          check_output("ex_operand2", OW'(ex_operand2), OW'(q[0].op2));
          check_output("ex_opp", ex_opp, q[0].opp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic v, input int prs1, input logic re1,
                                input int prs2, input logic re2,
                                input logic [DW-1:0] imm, input int tag);
    ro_valid   = v;
    ro_prs1    = AW'(prs1);
    ro_prs1_re = re1;
    ro_prs2    = AW'(prs2);
    ro_prs2_re = re2;
    ro_imm     = imm;
    ro_opp     = mk_opp(tag);
  endtask

  task automatic set_wb(input int port, input int prd, input logic [DW-1:0] dat);
    wb_we[port]             = 1'b1;
    wb_prd[port*AW +: AW]   = AW'(prd);
    wb_dat[port*DW +: DW]   = dat;
  endtask

  task automatic clear_wb();
    wb_we = '0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    wb_we = '0;
    wb_prd = '0;
    wb_dat = '0;
    apply_stimulus(1'b1, 5, 1'b1, 6, 1'b1, 64'h0, 1);
    #2;
    check_output("reset_ex_valid", OW'(ex_valid), OW'(0));
    check_output("reset_ro_rs_pop", OW'(ro_rs_pop), OW'(0));
    check_output("reset_prf_re", OW'(prf_re), OW'(0));
    step(2);
    rst = 1'b0;

    // Basic read and back-to-back throughput
    step(1);
    apply_stimulus(1'b1, 7, 1'b1, 8, 1'b1, 64'h0, 2);
    step(1);
    apply_stimulus(1'b1, 9, 1'b1, 10, 1'b1, 64'h0, 3);
    step(1);
    ro_valid = 1'b0;
    step(3);
    check_output("t1_op1", OW'(got1[1]), OW'(64'h11));
    check_output("t1_op2", OW'(got2[1]), OW'(64'h22));
    check_output("t1_tag3_op2", OW'(got2[3]), OW'(64'h100A));

    // Early bypass: writeback in the pop cycle
    apply_stimulus(1'b1, 5, 1'b1, 6, 1'b1, 64'h0, 4);
    set_wb(0, 5, 64'hAA);
    step(1);
    clear_wb();
    ro_valid = 1'b0;
    step(3);
    check_output("t2_op1_early", OW'(got1[4]), OW'(64'hAA));
    check_output("t2_op2", OW'(got2[4]), OW'(64'h22));

    // Late bypass on port 0, then early and late on port 1
    apply_stimulus(1'b1, 12, 1'b1, 6, 1'b1, 64'h0, 5);
    step(1);
    ro_valid = 1'b0;
    set_wb(0, 6, 64'hBB);
    step(1);
    clear_wb();
    step(2);
    check_output("t3_op2_late", OW'(got2[5]), OW'(64'hBB));
    apply_stimulus(1'b1, 20, 1'b1, 21, 1'b1, 64'h0, 6);
    set_wb(1, 20, 64'hC1);
    step(1);
    ro_valid = 1'b0;
    clear_wb();
    set_wb(1, 21, 64'hC2);
    step(1);
    clear_wb();
    step(2);
    check_output("t3_port1_early", OW'(got1[6]), OW'(64'hC1));
    check_output("t3_port1_late", OW'(got2[6]), OW'(64'hC2));

    // Back-pressure: S1 and S2 full for three cycles, then drain
    ex_ready = 1'b0;
    apply_stimulus(1'b1, 30, 1'b1, 31, 1'b1, 64'h0, 7);
    step(1);
    apply_stimulus(1'b1, 32, 1'b1, 33, 1'b1, 64'h0, 8);
    step(1);
    apply_stimulus(1'b1, 34, 1'b1, 35, 1'b1, 64'h0, 9);
    set_wb(0, 33, 64'hDD);
    check_output("t4_stall_pop", OW'(ro_rs_pop), OW'(0));
    step(1);
    clear_wb();
    set_wb(0, 32, 64'hEE);
    step(1);
    clear_wb();
    check_output("t4_stall_opp", OW'(ex_opp), mk_opp(7));
    step(1);
    ex_ready = 1'b1;
    step(1);
    ro_valid = 1'b0;
    step(4);
    check_output("t4_tag7_op1", OW'(got1[7]), OW'(64'h101E));
    check_output("t4_tag8_op1", OW'(got1[8]), OW'(64'h1020));
    check_output("t4_tag8_op2", OW'(got2[8]), OW'(64'hDD));
    check_output("t4_tag9_op2", OW'(got2[9]), OW'(64'h1023));

    // Unused sources: zero and immediate, writebacks must not leak in
    apply_stimulus(1'b1, 5, 1'b0, 6, 1'b0, 64'h1234, 10);
    set_wb(0, 5, 64'hF0);
    set_wb(1, 6, 64'hF1);
    step(1);
    clear_wb();
    ro_valid = 1'b0;
    step(3);
    check_output("t5_op1_zero", OW'(got1[10]), OW'(64'h0));
    check_output("t5_op2_imm", OW'(got2[10]), OW'(64'h1234));

    // Flush with both stages full and the RS still offering
    ex_ready = 1'b0;
    apply_stimulus(1'b1, 40, 1'b1, 41, 1'b1, 64'h0, 11);
    step(1);
    apply_stimulus(1'b1, 42, 1'b1, 43, 1'b1, 64'h0, 12);
    step(1);
    apply_stimulus(1'b1, 44, 1'b1, 45, 1'b1, 64'h0, 13);
    flush = 1'b1;
    check_output("t6_flush_pop", OW'(ro_rs_pop), OW'(0));
    check_output("t6_ex_valid_before", OW'(ex_valid), OW'(1));
    step(1);
    flush = 1'b0;
    ro_valid = 1'b0;
    check_output("t6_ex_valid_after", OW'(ex_valid), OW'(0));
    ex_ready = 1'b1;
    step(3);
    check_output("t6_killed", OW'({seen[11], seen[12], seen[13]}), OW'(0));

    // Asynchronous reset in the middle of a cycle with the stage full
    ex_ready = 1'b0;
    apply_stimulus(1'b1, 46, 1'b1, 47, 1'b1, 64'h0, 14);
    step(1);
    apply_stimulus(1'b1, 48, 1'b1, 49, 1'b1, 64'h0, 15);
    step(1);
    apply_stimulus(1'b1, 50, 1'b1, 51, 1'b1, 64'h0, 16);
    #2;
    rst = 1'b1;
    #1;
    check_output("t7_rst_ex_valid", OW'(ex_valid), OW'(0));
    check_output("t7_rst_pop", OW'(ro_rs_pop), OW'(0));
    check_output("t7_rst_prf_re", OW'(prf_re), OW'(0));
    step(2);
    rst = 1'b0;
    ro_valid = 1'b0;
    ex_ready = 1'b1;
    apply_stimulus(1'b1, 3, 1'b1, 4, 1'b1, 64'h0, 17);
    step(1);
    ro_valid = 1'b0;
    step(3);
    check_output("t7_after_rst_op1", OW'(got1[17]), OW'(64'h1003));
    check_output("t7_after_rst_op2", OW'(got2[17]), OW'(64'h1004));
    check_output("t7_killed", OW'({seen[14], seen[15], seen[16]}), OW'(0));
    check_output("drain", OW'(q.size()), OW'(0));

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
